// File: rtl/data_mem_responder_if.sv
// ----------------------------------------------------------------------------
// data_mem_responder_if
// Memory-stage data bus between the datapath M stage (master) and the data
// memory responder (slave).
//   req_valid/req_ready : request handshake, valid held until resp_valid
//   req_we              : 1 = store, 0 = load
//   req_size            : 00 byte, 01 half, 10 word, 11 illegal
//   req_signed          : load extension, 1 = sign, 0 = zero
//   req_addr            : byte address
//   req_wdata           : low-aligned store data
//   resp_valid          : one-cycle response pulse
//   resp_rdata          : extended load data (0 for stores / errors)
//   resp_err            : misaligned / illegal size, qualified by resp_valid
//   stall               : request pending and not yet answered
// ----------------------------------------------------------------------------
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        stall;

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, stall
    );

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err, stall
    );
endinterface

// File: rtl/data_mem_responder.sv
// ----------------------------------------------------------------------------
// data_mem_responder
// Responder for the M-stage data interface. Accepts one load/store at a time,
// performs the access LATENCY cycles after the accept edge on a 2**ADDR_W x 32
// word memory with little-endian byte/half/word lane steering, and returns
// extended load data or a misalignment error as a one-cycle response.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset (memory contents are kept)
//   bus  : data_mem_responder_if slave modport (request, response, stall)
// ----------------------------------------------------------------------------
module data_mem_responder #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    data_mem_responder_if.slave   bus
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    localparam logic [2:0] CNT_INIT = 3'(LATENCY - 1);

    state_t              r_state;
    state_t              w_next;
    logic [2:0]          r_cnt;

    logic                r_we;
    logic [1:0]          r_size;
    logic                r_signed;
    logic [ADDR_W+1:0]   r_addr;
    logic [31:0]         r_wdata;

    logic [31:0]         r_rdata;
    logic                r_err;

    logic [31:0]         r_mem [2**ADDR_W];

    logic                w_accept;
    logic                w_fire;
    logic [ADDR_W-1:0]   w_idx;
    logic [1:0]          w_lane;
    logic [31:0]         w_word;
    logic                w_misal;
    logic [3:0]          w_be;
    logic [31:0]         w_wrep;
    logic [7:0]          w_b8;
    logic [15:0]         w_h16;
    logic [31:0]         w_load;

    assign w_accept = (r_state == S_IDLE) && bus.req_valid;
    // Access happens on the edge that leaves WAIT, i.e. the response edge.
    assign w_fire   = (r_state == S_WAIT) && (r_cnt == '0);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.req_valid) w_next = S_WAIT;
            S_WAIT:  if (r_cnt == '0)   w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        bus.req_ready  = (r_state == S_IDLE);
        bus.resp_valid = (r_state == S_RESP);
        bus.resp_rdata = r_rdata;
        bus.resp_err   = r_err;
        bus.stall      = bus.req_valid && (r_state != S_RESP);
    end

    // Request latch and latency counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_we     <= 1'b0;
            r_size   <= '0;
            r_signed <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
        end else if (w_accept) begin
            r_cnt    <= CNT_INIT;
            r_we     <= bus.req_we;
            r_size   <= bus.req_size;
            r_signed <= bus.req_signed;
            r_addr   <= bus.req_addr[ADDR_W+1:0];
            r_wdata  <= bus.req_wdata;
        end else if ((r_state == S_WAIT) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 3'd1;
        end
    end

    assign w_idx  = r_addr[ADDR_W+1:2];
    assign w_lane = r_addr[1:0];
    assign w_word = r_mem[w_idx];
    assign w_b8   = w_word[{w_lane, 3'b000} +: 8];
    assign w_h16  = w_word[{w_lane[1], 4'b0000} +: 16];

    // Store data is replicated across lanes; the byte enables pick the lane.
    always_comb begin
        w_misal = 1'b0;
        w_be    = '0;
        w_wrep  = r_wdata;
        w_load  = w_word;
        case (r_size)
            2'b00: begin
                w_be   = 4'b0001 << w_lane;
                w_wrep = {4{r_wdata[7:0]}};
                w_load = {{24{r_signed & w_b8[7]}}, w_b8};
            end
            2'b01: begin
                w_misal = w_lane[0];
                w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
                w_wrep  = {2{r_wdata[15:0]}};
                w_load  = {{16{r_signed & w_h16[15]}}, w_h16};
            end
            2'b10: begin
                w_misal = |w_lane;
                w_be    = 4'b1111;
            end
            default: begin
                w_misal = 1'b1;
            end
        endcase
    end

    // Memory is never reset; a reset clears the FSM so no pending write fires.
    always_ff @(posedge clk) begin
        if (w_fire && r_we && !w_misal) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wrep[8*i +: 8];
            end
        end
    end

    // Response data/error hold their values outside resp_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (w_fire) begin
            r_err   <= w_misal;
            r_rdata <= (w_misal || r_we) ? '0 : w_load;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// ----------------------------------------------------------------------------
// tb_data_mem_responder
// Directed bench for data_mem_responder at LATENCY 1, 2 and 7. A transaction
// level model (byte-array memory, accept/response cycle bookkeeping) predicts
// every output each cycle; directed loads also carry hand-computed values.
// ----------------------------------------------------------------------------
module tb_data_mem_responder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        v   [3];
    logic        we  [3];
    logic [1:0]  sz  [3];
    logic        sg  [3];
    logic [31:0] ad  [3];
    logic [31:0] wd  [3];
    logic        rdy [3];
    logic        rv  [3];
    logic [31:0] rdo [3];
    logic        ero [3];
    logic        stl [3];

    data_mem_responder_if bus [3] ();

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned L = (g == 0) ? 1 : (g == 1) ? 2 : 7;
        assign bus[g].req_valid  = v[g];
        assign bus[g].req_we     = we[g];
        assign bus[g].req_size   = sz[g];
        assign bus[g].req_signed = sg[g];
        assign bus[g].req_addr   = ad[g];
        assign bus[g].req_wdata  = wd[g];
        assign rdy[g] = bus[g].req_ready;
        assign rv[g]  = bus[g].resp_valid;
        assign rdo[g] = bus[g].resp_rdata;
        assign ero[g] = bus[g].resp_err;
        assign stl[g] = bus[g].stall;
        data_mem_responder #(.ADDR_W(10), .LATENCY(L)) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus[g])
        );
    end

    int n_tests = 0;
    int n_fail  = 0;

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : (k == 1) ? 2 : 7;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    bit [7:0]    mm    [3][4096];
    int          cyc = 0;
    bit          pend  [3] = '{0, 0, 0};
    int          due   [3];
    int          nfree [3] = '{0, 0, 0};
    bit          p_we  [3];
    logic [1:0]  p_sz  [3];
    bit          p_sg  [3];
    logic [31:0] p_ad  [3];
    logic [31:0] p_wd  [3];
    bit          e_rv  [3] = '{0, 0, 0};
    logic [31:0] e_rd  [3] = '{0, 0, 0};
    bit          e_er  [3] = '{0, 0, 0};

    function automatic void resolve(input int k, output logic [31:0] r, output bit e);
        int a;
        int nb;
        longint val;
        a  = int'(p_ad[k] & 32'hFFF);
        nb = 1 << p_sz[k];
        r  = '0;
        e  = (p_sz[k] == 2'b11) || ((a % nb) != 0);
        if (!e) begin
            if (p_we[k]) begin
                for (int i = 0; i < nb; i++) mm[k][a+i] = 8'((p_wd[k] >> (8*i)) & 32'hFF);
            end else begin
                val = 0;
                for (int i = 0; i < nb; i++) val = val + (longint'(mm[k][a+i]) << (8*i));
                if (p_sg[k] && ((val >> (8*nb - 1)) & 1) == 1) val = val - (longint'(1) << (8*nb));
                r = 32'(val);
            end
        end
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 3; k++) begin
                pend[k] = 0; nfree[k] = 0;
                e_rv[k] = 0; e_rd[k] = '0; e_er[k] = 0;
            end
        end else begin
            cyc = cyc + 1;
            for (int k = 0; k < 3; k++) begin
                e_rv[k] = 0;
                if (pend[k] && cyc == due[k]) begin
                    resolve(k, e_rd[k], e_er[k]);
                    e_rv[k]  = 1;
                    pend[k]  = 0;
                    nfree[k] = cyc + 2;
                end else if (!pend[k] && cyc >= nfree[k] && v[k] === 1'b1) begin
                    p_we[k] = we[k]; p_sz[k] = sz[k]; p_sg[k] = sg[k];
                    p_ad[k] = ad[k]; p_wd[k] = wd[k];
                    pend[k] = 1;
                    due[k]  = cyc + lat_of(k);
                end
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("L%0d resp_valid", lat_of(k)), 32'(rv[k]),  32'(e_rv[k]));
            chk($sformatf("L%0d resp_rdata", lat_of(k)), rdo[k],      e_rd[k]);
            chk($sformatf("L%0d resp_err",   lat_of(k)), 32'(ero[k]), 32'(e_er[k]));
            chk($sformatf("L%0d req_ready",  lat_of(k)), 32'(rdy[k]),
                32'(!pend[k] && (cyc + 1 >= nfree[k])));
            chk($sformatf("L%0d stall",      lat_of(k)), 32'(stl[k]),
                32'(v[k] && !e_rv[k]));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic do_req(input int k, input logic w, input logic [1:0] s, input logic sgn,
                          input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] r, output logic e, output int lat);
        bit seen;
        bit done;
        int acc;
        @(posedge clk); #1;
        we[k] = w; sz[k] = s; sg[k] = sgn; ad[k] = a; wd[k] = d; v[k] = 1'b1;
        seen = 0; done = 0; acc = 0; lat = -1; r = '0; e = 1'b0;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk);
            if (rv[k]) begin
                r = rdo[k]; e = ero[k]; lat = cyc - acc; done = 1;
            end else if (!seen && rdy[k]) begin
                seen = 1; acc = cyc + 1;
            end
            @(posedge clk); #1;
            // Fields after the accept edge must not matter.
            if (seen && !done) begin
                we[k] = ~w; sz[k] = s ^ 2'b01; sg[k] = ~sgn; ad[k] = $urandom; wd[k] = $urandom;
            end
        end
        v[k] = 1'b0;
        chk($sformatf("L%0d response timeout", lat_of(k)), 32'(done), 32'd1);
    endtask

    task automatic run_suite(input int k);
        logic [31:0] r;
        logic e;
        int lat;
        int L;
        int cnt;
        bit ok;
        string p;
        L = lat_of(k);
        p = $sformatf("L%0d", L);

        do_req(k, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, r, e, lat);
        chk({p, " sw latency"}, 32'(lat), 32'(L));
        chk({p, " sw err"}, 32'(e), 0);
        chk({p, " sw rdata"}, r, 0);
        do_req(k, 0, 2'b10, 0, 32'h10, 0, r, e, lat);
        chk({p, " lw 0x10"}, r, 32'hDEADBEEF);
        chk({p, " lw latency"}, 32'(lat), 32'(L));

        do_req(k, 1, 2'b10, 0, 32'h10, 32'h11223344, r, e, lat);
        do_req(k, 1, 2'b00, 0, 32'h13, 32'h000000A5, r, e, lat);
        do_req(k, 0, 2'b10, 0, 32'h10, 0, r, e, lat);
        chk({p, " lw after sb"}, r, 32'hA5223344);
        do_req(k, 0, 2'b00, 1, 32'h13, 0, r, e, lat);
        chk({p, " lb 0x13"}, r, 32'hFFFFFFA5);
        do_req(k, 0, 2'b00, 0, 32'h13, 0, r, e, lat);
        chk({p, " lbu 0x13"}, r, 32'h000000A5);

        do_req(k, 1, 2'b10, 0, 32'h14, 32'hCAFEF00D, r, e, lat);
        do_req(k, 1, 2'b01, 0, 32'h16, 32'h00008001, r, e, lat);
        do_req(k, 0, 2'b01, 1, 32'h16, 0, r, e, lat);
        chk({p, " lh 0x16"}, r, 32'hFFFF8001);
        do_req(k, 0, 2'b01, 0, 32'h16, 0, r, e, lat);
        chk({p, " lhu 0x16"}, r, 32'h00008001);
        do_req(k, 0, 2'b10, 0, 32'h14, 0, r, e, lat);
        chk({p, " lw 0x14"}, r, 32'h8001F00D);

        do_req(k, 0, 2'b10, 0, 32'h12, 0, r, e, lat);
        chk({p, " lw 0x12 err"}, 32'(e), 1);
        chk({p, " lw 0x12 rdata"}, r, 0);
        do_req(k, 1, 2'b01, 0, 32'h11, 32'h0000FFFF, r, e, lat);
        chk({p, " sh 0x11 err"}, 32'(e), 1);
        do_req(k, 0, 2'b11, 0, 32'h10, 0, r, e, lat);
        chk({p, " size11 err"}, 32'(e), 1);
        chk({p, " size11 rdata"}, r, 0);
        do_req(k, 1, 2'b10, 0, 32'h12, 32'h00000000, r, e, lat);
        chk({p, " sw 0x12 err"}, 32'(e), 1);
        do_req(k, 0, 2'b10, 0, 32'h10, 0, r, e, lat);
        chk({p, " lw 0x10 unchanged"}, r, 32'hA5223344);
        do_req(k, 0, 2'b10, 0, 32'h1010, 0, r, e, lat);
        chk({p, " lw wrap 0x1010"}, r, 32'hA5223344);

        // req_valid held continuously: accepts every L+2 edges, 3 responses in 3L+6 edges.
        @(posedge clk); #1;
        we[k] = 0; sz[k] = 2'b10; sg[k] = 0; ad[k] = 32'h14; wd[k] = 0; v[k] = 1'b1;
        cnt = 0;
        repeat (3*L + 6) begin
            @(posedge clk);
            @(negedge clk);
            if (rv[k]) cnt++;
        end
        #1 v[k] = 1'b0;
        chk({p, " back-to-back responses"}, 32'(cnt), 3);
        repeat (L + 4) @(posedge clk);

        // Reset in the middle of a store.
        do_req(k, 1, 2'b10, 0, 32'h20, 32'hABCD0123, r, e, lat);
        do_req(k, 0, 2'b10, 0, 32'h10, 0, r, e, lat);
        @(posedge clk); #1;
        we[k] = 1; sz[k] = 2'b10; sg[k] = 0; ad[k] = 32'h20; wd[k] = 32'h12345678; v[k] = 1'b1;
        ok = 0;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            if (rdy[k]) ok = 1;
        end
        chk({p, " rst-test accept"}, 32'(ok), 1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk({p, " rst resp_valid"}, 32'(rv[k]), 0);
        chk({p, " rst req_ready"}, 32'(rdy[k]), 1);
        chk({p, " rst resp_rdata"}, rdo[k], 0);
        chk({p, " rst resp_err"}, 32'(ero[k]), 0);
        v[k] = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        cnt = 0;
        repeat (L + 3) begin
            @(negedge clk);
            if (rv[k]) cnt++;
        end
        chk({p, " no resp after rst"}, 32'(cnt), 0);
        do_req(k, 0, 2'b10, 0, 32'h20, 0, r, e, lat);
        chk({p, " lw 0x20 after abort"}, r, 32'hABCD0123);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            v[k] = 0; we[k] = 0; sz[k] = '0; sg[k] = 0; ad[k] = '0; wd[k] = '0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("L%0d reset req_ready", lat_of(k)), 32'(rdy[k]), 1);
            chk($sformatf("L%0d reset resp_valid", lat_of(k)), 32'(rv[k]), 0);
            chk($sformatf("L%0d reset resp_rdata", lat_of(k)), rdo[k], 0);
            chk($sformatf("L%0d reset resp_err", lat_of(k)), 32'(ero[k]), 0);
            chk($sformatf("L%0d reset stall", lat_of(k)), 32'(stl[k]), 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) run_suite(k);
        repeat (4) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
